// File: rtl/timer8254_pkg.sv
// Shared constants for the 8254 timer channel logic: control-word RW field
// encodings and the fixed count width.
package timer8254_pkg;

   localparam int COUNT_W = 16;

   localparam logic [1:0] RW_LATCH   = 2'b00;
   localparam logic [1:0] RW_LSB     = 2'b01;
   localparam logic [1:0] RW_MSB     = 2'b10;
   localparam logic [1:0] RW_LSB_MSB = 2'b11;

endpackage

// File: rtl/count_output_latch.sv
// Output latch (OL) for one 8254 channel: freezes the live CE value on a
// counter-latch command and serves it byte-wise to bus reads in the order
// selected by the programmed RW field. Used only when COUNT_LATCH_EN is set.
module count_output_latch
   import timer8254_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             prog_clr,
   input  logic [1:0]       rw_q,
   input  logic [WIDTH-1:0] ce_count,
   input  logic             latch_cmd,
   input  logic             rd_stb,
   output logic [7:0]       rd_data
);

   logic [WIDTH-1:0] ol_q, ol_d;
   logic             latched_q, latched_d;
   logic             rd_msb_q, rd_msb_d;

   logic [WIDTH-1:0] rd_src;
   logic             rd_sel_msb;
   logic             rd_final;

   // Read source/byte select and next-state for OL, latched flag, read pointer.
   always_comb begin
      rd_src     = latched_q ? ol_q : ce_count;
      rd_sel_msb = (rw_q == RW_MSB) || ((rw_q == RW_LSB_MSB) && rd_msb_q);
      rd_data    = rd_sel_msb ? rd_src[WIDTH-1:8] : rd_src[7:0];
      rd_final   = (rw_q != RW_LSB_MSB) || rd_msb_q;

      ol_d      = ol_q;
      latched_d = latched_q;
      rd_msb_d  = rd_msb_q;

      if (prog_clr) begin
         latched_d = 1'b0;
         rd_msb_d  = 1'b0;
      end else begin
         // The read sees the pre-latch source; a same-cycle latch lands after it.
         if (rd_stb) begin
            if (rw_q == RW_LSB_MSB) rd_msb_d = ~rd_msb_q;
            if (rd_final) latched_d = 1'b0;
         end
         // First latch wins: further commands are ignored until the read completes.
         if (latch_cmd && !latched_q) begin
            ol_d      = ce_count;
            latched_d = 1'b1;
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ol_q      <= '0;
         latched_q <= 1'b0;
         rd_msb_q  <= 1'b0;
      end else begin
         ol_q      <= ol_d;
         latched_q <= latched_d;
         rd_msb_q  <= rd_msb_d;
      end
   end

endmodule

// File: rtl/count_register_rw.sv
// Programmable 16-bit count register (CR) for one 8254 channel. Captures the
// initial count from the data bus in LSB, MSB or LSB-then-MSB form, strobes
// the counting element when a full count is written, and tracks null count.
// Define COUNT_LATCH_EN to add the counter-latch / read-back path.
module count_register_rw
   import timer8254_pkg::*;
#(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_COUNT = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       databus,
   input  logic             wr_stb,
   input  logic             mode_prog,
   input  logic [1:0]       rw_mode,
   input  logic             ce_loaded,
   output logic [WIDTH-1:0] initial_count,
   output logic             load_stb,
   output logic             null_count,
   output logic             wr_msb_next
`ifdef COUNT_LATCH_EN
   ,
   input  logic [WIDTH-1:0] ce_count,
   input  logic             latch_cmd,
   input  logic             rd_stb,
   output logic [7:0]       rd_data
`endif
);

   if (WIDTH != COUNT_W) begin : g_width_check
      $error("count_register_rw: WIDTH must be 16");
   end

   logic [1:0]       rw_q, rw_d;
   logic [WIDTH-1:0] cr_q, cr_d;
   logic             wr_msb_next_q, wr_msb_next_d;
   logic             load_stb_q, load_stb_d;
   logic             null_count_q, null_count_d;

   logic             prog_valid;
   logic             wr_accept;

   // Mode programming takes priority; otherwise steer the written byte by RW.
   always_comb begin
      prog_valid = mode_prog && (rw_mode != RW_LATCH);
      // Any control word in the same cycle, even a latch command, drops the write.
      wr_accept  = wr_stb && !mode_prog;

      rw_d          = rw_q;
      cr_d          = cr_q;
      wr_msb_next_d = wr_msb_next_q;
      load_stb_d    = 1'b0;
      null_count_d  = null_count_q;

      if (prog_valid) begin
         rw_d          = rw_mode;
         cr_d          = RESET_COUNT;
         wr_msb_next_d = 1'b0;
         null_count_d  = 1'b1;
      end else begin
         if (wr_accept) begin
            null_count_d = 1'b1;
            case (rw_q)
               RW_LSB: begin
                  cr_d       = {8'h00, databus};
                  load_stb_d = 1'b1;
               end
               RW_MSB: begin
                  cr_d       = {databus, 8'h00};
                  load_stb_d = 1'b1;
               end
               RW_LSB_MSB: begin
                  if (!wr_msb_next_q) begin
                     cr_d[7:0]     = databus;
                     wr_msb_next_d = 1'b1;
                  end else begin
                     cr_d[WIDTH-1:8] = databus;
                     wr_msb_next_d   = 1'b0;
                     load_stb_d      = 1'b1;
                  end
               end
               default: ;
            endcase
         end else if (ce_loaded) begin
            null_count_d = 1'b0;
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rw_q          <= RW_LSB;
         cr_q          <= RESET_COUNT;
         wr_msb_next_q <= 1'b0;
         load_stb_q    <= 1'b0;
         null_count_q  <= 1'b1;
      end else begin
         rw_q          <= rw_d;
         cr_q          <= cr_d;
         wr_msb_next_q <= wr_msb_next_d;
         load_stb_q    <= load_stb_d;
         null_count_q  <= null_count_d;
      end
   end

   assign initial_count = cr_q;
   assign load_stb      = load_stb_q;
   assign null_count    = null_count_q;
   assign wr_msb_next   = wr_msb_next_q;

`ifdef COUNT_LATCH_EN
   count_output_latch #(
      .WIDTH (WIDTH)
   ) u_output_latch (
      .clk       (clk),
      .reset     (reset),
      .prog_clr  (prog_valid),
      .rw_q      (rw_q),
      .ce_count  (ce_count),
      .latch_cmd (latch_cmd),
      .rd_stb    (rd_stb),
      .rd_data   (rd_data)
   );
`endif

endmodule
